// File: rtl/alu_control_datamem.sv
// Execution slice of the single-cycle MIPS core: instruction decoder, 32-bit ALU and data RAM.
// Optional feature macro: ALU_OVF_EN enables signed-overflow detection on alu_ovf.
module alu_control_datamem #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        irq,
  input  logic        exc,
  output logic [1:0]  PCSrc,
  output logic [1:0]  RegDst,
  output logic        RegWr,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic        Sign,
  output logic        MemWr,
  output logic        MemRd,
  output logic        EXTOp,
  output logic        LUOp,
  output logic [5:0]  ALUFun,
  output logic [1:0]  MemToReg,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_out,
  output logic        alu_ovf,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b011000;
  localparam logic [5:0] FN_OR  = 6'b011110;
  localparam logic [5:0] FN_XOR = 6'b010110;
  localparam logic [5:0] FN_NOR = 6'b010001;
  localparam logic [5:0] FN_A   = 6'b011010;
  localparam logic [5:0] FN_SLL = 6'b100000;
  localparam logic [5:0] FN_SRL = 6'b100001;
  localparam logic [5:0] FN_SRA = 6'b100011;
  localparam logic [5:0] FN_EQ  = 6'b110011;
  localparam logic [5:0] FN_NEQ = 6'b110001;
  localparam logic [5:0] FN_LT  = 6'b110101;
  localparam logic [5:0] FN_LEZ = 6'b111101;
  localparam logic [5:0] FN_LTZ = 6'b111011;
  localparam logic [5:0] FN_GTZ = 6'b111111;

  // ---------------- decoder ----------------
  always_comb begin
    PCSrc    = 2'b00;
    RegDst   = 2'b00;
    RegWr    = 1'b0;
    ALUSrc1  = 1'b0;
    ALUSrc2  = 1'b0;
    Sign     = 1'b1;
    MemWr    = 1'b0;
    MemRd    = 1'b0;
    EXTOp    = 1'b1;
    LUOp     = 1'b0;
    MemToReg = 2'b00;
    ALUFun   = FN_ADD;

    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin RegWr = 1'b1; ALUFun = FN_ADD; end
          6'h21: begin RegWr = 1'b1; ALUFun = FN_ADD; Sign = 1'b0; end
          6'h22: begin RegWr = 1'b1; ALUFun = FN_SUB; end
          6'h23: begin RegWr = 1'b1; ALUFun = FN_SUB; Sign = 1'b0; end
          6'h24: begin RegWr = 1'b1; ALUFun = FN_AND; end
          6'h25: begin RegWr = 1'b1; ALUFun = FN_OR;  end
          6'h26: begin RegWr = 1'b1; ALUFun = FN_XOR; end
          6'h27: begin RegWr = 1'b1; ALUFun = FN_NOR; end
          6'h2a: begin RegWr = 1'b1; ALUFun = FN_LT;  end
          6'h2b: begin RegWr = 1'b1; ALUFun = FN_LT;  Sign = 1'b0; end
          6'h00: begin RegWr = 1'b1; ALUFun = FN_SLL; ALUSrc1 = 1'b1; end
          6'h02: begin RegWr = 1'b1; ALUFun = FN_SRL; ALUSrc1 = 1'b1; end
          6'h03: begin RegWr = 1'b1; ALUFun = FN_SRA; ALUSrc1 = 1'b1; end
          6'h08: PCSrc = 2'b11;
          6'h09: begin PCSrc = 2'b11; RegWr = 1'b1; MemToReg = 2'b10; end
          default: ;
        endcase
      end
      6'h23: begin RegWr = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; MemRd = 1'b1; MemToReg = 2'b01; end
      6'h2b: begin ALUSrc2 = 1'b1; MemWr = 1'b1; end
      6'h0f: begin RegWr = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; LUOp = 1'b1; end
      6'h08: begin RegWr = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; end
      6'h09: begin RegWr = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; Sign = 1'b0; end
      6'h0c: begin RegWr = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; EXTOp = 1'b0; ALUFun = FN_AND; end
      6'h0d: begin RegWr = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; EXTOp = 1'b0; ALUFun = FN_OR; end
      6'h0a: begin RegWr = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; ALUFun = FN_LT; end
      6'h0b: begin RegWr = 1'b1; RegDst = 2'b01; ALUSrc2 = 1'b1; ALUFun = FN_LT; Sign = 1'b0; end
      6'h04: begin PCSrc = 2'b01; ALUFun = FN_EQ;  end
      6'h05: begin PCSrc = 2'b01; ALUFun = FN_NEQ; end
      6'h06: begin PCSrc = 2'b01; ALUFun = FN_LEZ; end
      6'h07: begin PCSrc = 2'b01; ALUFun = FN_GTZ; end
      6'h01: begin PCSrc = 2'b01; ALUFun = FN_LTZ; end
      6'h02: PCSrc = 2'b10;
      6'h03: begin PCSrc = 2'b10; RegWr = 1'b1; RegDst = 2'b10; MemToReg = 2'b10; end
      default: ;
    endcase

    // Trap entry: save PC+4 into $26 and let the top level force the vector.
    if (irq || exc) begin
      RegWr    = 1'b1;
      RegDst   = 2'b11;
      MemToReg = 2'b10;
      MemWr    = 1'b0;
      MemRd    = 1'b0;
      PCSrc    = 2'b00;
    end
  end

  // ---------------- ALU ----------------
  logic [31:0] sum;
  logic [31:0] diff;
  logic        lt_flag;

  assign sum     = alu_a + alu_b;
  assign diff    = alu_a - alu_b;
  assign lt_flag = Sign ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);

  always_comb begin
    alu_out = 32'h0;
    case (ALUFun)
      FN_ADD: alu_out = sum;
      FN_SUB: alu_out = diff;
      FN_AND: alu_out = alu_a & alu_b;
      FN_OR:  alu_out = alu_a | alu_b;
      FN_XOR: alu_out = alu_a ^ alu_b;
      FN_NOR: alu_out = ~(alu_a | alu_b);
      FN_A:   alu_out = alu_a;
      FN_SLL: alu_out = alu_b << alu_a[4:0];
      FN_SRL: alu_out = alu_b >> alu_a[4:0];
      FN_SRA: alu_out = $signed(alu_b) >>> alu_a[4:0];
      FN_EQ:  alu_out = {31'b0, alu_a == alu_b};
      FN_NEQ: alu_out = {31'b0, alu_a != alu_b};
      FN_LT:  alu_out = {31'b0, lt_flag};
      FN_LEZ: alu_out = {31'b0, alu_a[31] || (alu_a == 32'h0)};
      FN_LTZ: alu_out = {31'b0, alu_a[31]};
      FN_GTZ: alu_out = {31'b0, !alu_a[31] && (alu_a != 32'h0)};
      default: alu_out = 32'h0;
    endcase
  end

`ifdef ALU_OVF_EN
  always_comb begin
    alu_ovf = 1'b0;
    if (Sign) begin
      if (ALUFun == FN_ADD)
        alu_ovf = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      else if (ALUFun == FN_SUB)
        alu_ovf = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
    end
  end
`else
  assign alu_ovf = 1'b0;
`endif

  // ---------------- data RAM ----------------
  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          unused_addr_bits;

  assign idx              = mem_addr[AW+1:2];
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // Power-of-two depth covers every index, so no comparator is needed there.
  if (MEM_WORDS == (1 << AW)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (32'(idx) < MEM_WORDS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
    end else if (mem_wr && in_range) begin
      mem[idx] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_rd && in_range) ? mem[idx] : 32'h0;

endmodule

// File: tb/tb_alu_control_datamem.sv
// Self-checking bench for alu_control_datamem: directed plan steps plus randomized
// instruction/operand and RAM traffic against a behavioural model.
module tb_alu_control_datamem;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        irq, exc;
  logic [1:0]  PCSrc, RegDst, MemToReg;
  logic        RegWr, ALUSrc1, ALUSrc2, Sign, MemWr, MemRd, EXTOp, LUOp;
  logic [5:0]  ALUFun;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_ovf;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  alu_control_datamem #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .irq(irq), .exc(exc),
    .PCSrc(PCSrc), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
    .Sign(Sign), .MemWr(MemWr), .MemRd(MemRd), .EXTOp(EXTOp), .LUOp(LUOp),
    .ALUFun(ALUFun), .MemToReg(MemToReg), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_ovf(alu_ovf), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

`ifdef ALU_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // Packed control vector: {PCSrc,RegDst,RegWr,ALUSrc1,ALUSrc2,Sign,MemWr,MemRd,EXTOp,LUOp,MemToReg,ALUFun}
  localparam logic [19:0] F_PC  = 20'hC0000;
  localparam logic [19:0] F_DST = 20'h30000;
  localparam logic [19:0] F_WR  = 20'h08000;
  localparam logic [19:0] F_A1  = 20'h04000;
  localparam logic [19:0] F_A2  = 20'h02000;
  localparam logic [19:0] F_MW  = 20'h00800;
  localparam logic [19:0] F_MR  = 20'h00400;
  localparam logic [19:0] F_M2R = 20'h000C0;
  localparam logic [19:0] F_FUN = 20'h0003F;
  localparam logic [19:0] M_ALL = 20'hFFFFF;
  localparam logic [19:0] M_NW  = M_ALL & ~(F_DST | F_M2R);
  localparam logic [19:0] M_J   = M_NW & ~(F_A1 | F_A2 | F_FUN);
  localparam logic [19:0] M_JAL = M_ALL & ~(F_A1 | F_A2 | F_FUN);
  localparam logic [19:0] M_UND = F_PC | F_WR | F_MW | F_MR;
  localparam logic [19:0] M_OVR = M_UND | F_DST | F_M2R;

  localparam logic [3:0] K_NONE = 4'd0, K_ADD = 4'd1, K_SUB = 4'd2, K_AND = 4'd3,
                         K_OR = 4'd4, K_XOR = 4'd5, K_NOR = 4'd6, K_LT = 4'd7,
                         K_SLL = 4'd8, K_SRL = 4'd9, K_SRA = 4'd10, K_EQ = 4'd11,
                         K_NE = 4'd12, K_LEZ = 4'd13, K_GTZ = 4'd14, K_LTZ = 4'd15;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  kind;
    logic [19:0] ctrl;
    logic [19:0] mask;
  } row_t;

  row_t        tbl[$];
  logic [19:0] obs_ctrl;
  assign obs_ctrl = {PCSrc, RegDst, RegWr, ALUSrc1, ALUSrc2, Sign, MemWr, MemRd,
                     EXTOp, LUOp, MemToReg, ALUFun};

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard / model ----------------
  logic [31:0] ram_m [256];

  function automatic logic [19:0] pk(logic [1:0] pc, logic [1:0] dst, logic wr, logic a1,
                                     logic a2, logic sg, logic mw, logic mr, logic ext,
                                     logic lu, logic [1:0] m2r, logic [5:0] fun);
    return {pc, dst, wr, a1, a2, sg, mw, mr, ext, lu, m2r, fun};
  endfunction

  function automatic row_t mk(logic [5:0] op, logic [5:0] fn, logic [3:0] k,
                              logic [19:0] c, logic [19:0] m);
    row_t r;
    r.op = op; r.fn = fn; r.kind = k; r.ctrl = c; r.mask = m;
    return r;
  endfunction

  // Instruction semantics on the operands, independent of any ALU encoding.
  function automatic logic [31:0] ref_alu(logic [3:0] k, logic sg, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    case (k)
      K_ADD: r = a + b;
      K_SUB: r = a - b;
      K_AND: r = a & b;
      K_OR:  r = a | b;
      K_XOR: r = a ^ b;
      K_NOR: r = ~(a | b);
      K_LT:  r = {31'b0, sg ? ($signed(a) < $signed(b)) : (a < b)};
      K_SLL: r = b << a[4:0];
      K_SRL: r = b >> a[4:0];
      K_SRA: r = $signed(b) >>> a[4:0];
      K_EQ:  r = {31'b0, a == b};
      K_NE:  r = {31'b0, a != b};
      K_LEZ: r = {31'b0, $signed(a) <= 0};
      K_GTZ: r = {31'b0, $signed(a) > 0};
      K_LTZ: r = {31'b0, $signed(a) < 0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Overflow: the exact signed result differs from the sign-extended 32-bit result.
  function automatic logic ref_ovf(logic [3:0] k, logic sg, logic [31:0] a, logic [31:0] b);
    longint exact;
    logic [31:0] wrapped;
    if (!OVF_ON || !sg || (k != K_ADD && k != K_SUB)) return 1'b0;
    exact   = (k == K_ADD) ? longint'($signed(a)) + longint'($signed(b))
                           : longint'($signed(a)) - longint'($signed(b));
    wrapped = 32'(exact);
    return exact != longint'($signed(wrapped));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
    opcode = op; funct = fn; alu_a = a; alu_b = b; irq = 1'b0; exc = 1'b0;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_write(input logic [31:0] addr, input logic [31:0] data);
    mem_addr = addr; mem_wdata = data; mem_wr = 1'b1;
    clock_edge();
    mem_wr = 1'b0;
    if (reset) ram_m[addr[9:2]] = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b, addr, data;
    row_t r;

    // R-type
    tbl.push_back(mk(6'h00, 6'h20, K_ADD, pk(0,0,1,0,0,1,0,0,1,0,0,6'b000000), M_ALL));
    tbl.push_back(mk(6'h00, 6'h21, K_ADD, pk(0,0,1,0,0,0,0,0,1,0,0,6'b000000), M_ALL));
    tbl.push_back(mk(6'h00, 6'h22, K_SUB, pk(0,0,1,0,0,1,0,0,1,0,0,6'b000001), M_ALL));
    tbl.push_back(mk(6'h00, 6'h23, K_SUB, pk(0,0,1,0,0,0,0,0,1,0,0,6'b000001), M_ALL));
    tbl.push_back(mk(6'h00, 6'h24, K_AND, pk(0,0,1,0,0,1,0,0,1,0,0,6'b011000), M_ALL));
    tbl.push_back(mk(6'h00, 6'h25, K_OR,  pk(0,0,1,0,0,1,0,0,1,0,0,6'b011110), M_ALL));
    tbl.push_back(mk(6'h00, 6'h26, K_XOR, pk(0,0,1,0,0,1,0,0,1,0,0,6'b010110), M_ALL));
    tbl.push_back(mk(6'h00, 6'h27, K_NOR, pk(0,0,1,0,0,1,0,0,1,0,0,6'b010001), M_ALL));
    tbl.push_back(mk(6'h00, 6'h2a, K_LT,  pk(0,0,1,0,0,1,0,0,1,0,0,6'b110101), M_ALL));
    tbl.push_back(mk(6'h00, 6'h2b, K_LT,  pk(0,0,1,0,0,0,0,0,1,0,0,6'b110101), M_ALL));
    tbl.push_back(mk(6'h00, 6'h00, K_SLL, pk(0,0,1,1,0,1,0,0,1,0,0,6'b100000), M_ALL));
    tbl.push_back(mk(6'h00, 6'h02, K_SRL, pk(0,0,1,1,0,1,0,0,1,0,0,6'b100001), M_ALL));
    tbl.push_back(mk(6'h00, 6'h03, K_SRA, pk(0,0,1,1,0,1,0,0,1,0,0,6'b100011), M_ALL));
    tbl.push_back(mk(6'h00, 6'h08, K_NONE, pk(3,0,0,0,0,1,0,0,1,0,0,6'b0), M_J));
    tbl.push_back(mk(6'h00, 6'h09, K_NONE, pk(3,0,1,0,0,1,0,0,1,0,2,6'b0), M_JAL));
    // I-type
    tbl.push_back(mk(6'h23, 6'h00, K_ADD, pk(0,1,1,0,1,1,0,1,1,0,1,6'b000000), M_ALL));
    tbl.push_back(mk(6'h2b, 6'h00, K_ADD, pk(0,0,0,0,1,1,1,0,1,0,0,6'b000000), M_NW));
    tbl.push_back(mk(6'h0f, 6'h00, K_ADD, pk(0,1,1,0,1,1,0,0,1,1,0,6'b000000), M_ALL));
    tbl.push_back(mk(6'h08, 6'h00, K_ADD, pk(0,1,1,0,1,1,0,0,1,0,0,6'b000000), M_ALL));
    tbl.push_back(mk(6'h09, 6'h00, K_ADD, pk(0,1,1,0,1,0,0,0,1,0,0,6'b000000), M_ALL));
    tbl.push_back(mk(6'h0c, 6'h00, K_AND, pk(0,1,1,0,1,1,0,0,0,0,0,6'b011000), M_ALL));
    tbl.push_back(mk(6'h0d, 6'h00, K_OR,  pk(0,1,1,0,1,1,0,0,0,0,0,6'b011110), M_ALL));
    tbl.push_back(mk(6'h0a, 6'h00, K_LT,  pk(0,1,1,0,1,1,0,0,1,0,0,6'b110101), M_ALL));
    tbl.push_back(mk(6'h0b, 6'h00, K_LT,  pk(0,1,1,0,1,0,0,0,1,0,0,6'b110101), M_ALL));
    // Branches and jumps
    tbl.push_back(mk(6'h04, 6'h00, K_EQ,  pk(1,0,0,0,0,1,0,0,1,0,0,6'b110011), M_NW));
    tbl.push_back(mk(6'h05, 6'h00, K_NE,  pk(1,0,0,0,0,1,0,0,1,0,0,6'b110001), M_NW));
    tbl.push_back(mk(6'h06, 6'h00, K_LEZ, pk(1,0,0,0,0,1,0,0,1,0,0,6'b111101), M_NW));
    tbl.push_back(mk(6'h07, 6'h00, K_GTZ, pk(1,0,0,0,0,1,0,0,1,0,0,6'b111111), M_NW));
    tbl.push_back(mk(6'h01, 6'h00, K_LTZ, pk(1,0,0,0,0,1,0,0,1,0,0,6'b111011), M_NW));
    tbl.push_back(mk(6'h02, 6'h00, K_NONE, pk(2,0,0,0,0,1,0,0,1,0,0,6'b0), M_J));
    tbl.push_back(mk(6'h03, 6'h00, K_NONE, pk(2,2,1,0,0,1,0,0,1,0,2,6'b0), M_JAL));

    // Reset state
    reset = 1'b1; irq = 1'b0; exc = 1'b0; opcode = 6'h00; funct = 6'h20;
    alu_a = 32'h0; alu_b = 32'h0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ram_m[i] = 32'h0;
    #1 reset = 1'b0;
    #1;
    mem_rd = 1'b1; mem_addr = 32'h10; #1;
    chk("reset_ram_0x10", mem_rdata, 32'h0);
    mem_addr = 32'h3FC; #1;
    chk("reset_ram_top", mem_rdata, 32'h0);
    set_instr(6'h00, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00);
    chk("comb_in_reset", alu_out, 32'h00F0_1200);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    clock_edge();

    // Directed plan: add/addu overflow, slt/sltu, sra, jal, exc override
    set_instr(6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1);
    chk("add_out", alu_out, 32'h8000_0000);
    chk("add_ovf", {31'b0, alu_ovf}, {31'b0, OVF_ON});
    set_instr(6'h00, 6'h21, 32'h7FFF_FFFF, 32'h1);
    chk("addu_ovf", {31'b0, alu_ovf}, 32'h0);
    chk("addu_sign", {31'b0, Sign}, 32'h0);
    set_instr(6'h00, 6'h2a, 32'hFFFF_FFFF, 32'h1);
    chk("slt_neg", alu_out, 32'h1);
    set_instr(6'h00, 6'h2b, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_big", alu_out, 32'h0);
    set_instr(6'h00, 6'h03, 32'h4, 32'h8000_0000);
    chk("sra_out", alu_out, 32'hF800_0000);
    chk("sra_alusrc1", {31'b0, ALUSrc1}, 32'h1);
    set_instr(6'h00, 6'h22, 32'h8000_0000, 32'h1);
    chk("sub_ovf", {31'b0, alu_ovf}, {31'b0, OVF_ON});
    set_instr(6'h03, 6'h00, 32'h0, 32'h0);
    chk("jal_pcsrc", {30'b0, PCSrc}, 32'h2);
    chk("jal_regdst", {30'b0, RegDst}, 32'h2);
    chk("jal_memtoreg", {30'b0, MemToReg}, 32'h2);
    chk("jal_regwr", {31'b0, RegWr}, 32'h1);
    opcode = 6'h2b; exc = 1'b1; #1;
    chk("exc_memwr", {31'b0, MemWr}, 32'h0);
    chk("exc_regdst", {30'b0, RegDst}, 32'h3);
    chk("exc_regwr", {31'b0, RegWr}, 32'h1);

    // Undefined opcodes / functs
    foreach (tbl[i]) ;
    for (int i = 0; i < 6; i++) begin
      logic [5:0] und_op [6];
      logic [5:0] und_fn [6];
      und_op = '{6'h3f, 6'h10, 6'h20, 6'h00, 6'h00, 6'h00};
      und_fn = '{6'h00, 6'h00, 6'h00, 6'h3f, 6'h01, 6'h10};
      set_instr(und_op[i], und_fn[i], $urandom, $urandom);
      chk("undef_ctrl", 32'(obs_ctrl & M_UND), 32'h0);
    end

    // Randomized instructions, operands and trap overrides
    for (int n = 0; n < 300; n++) begin
      r = tbl[$urandom_range(0, tbl.size() - 1)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) a = 32'h0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h7FFF_FFFF; b = $urandom_range(1, 8); end
      set_instr(r.op, (r.op == 6'h00) ? r.fn : 6'($urandom), a, b);
      chk("ctrl", 32'(obs_ctrl & r.mask), 32'(r.ctrl & r.mask));
      if (r.kind != K_NONE) begin
        chk("alu_out", alu_out, ref_alu(r.kind, r.ctrl[12], a, b));
        chk("alu_ovf", {31'b0, alu_ovf}, {31'b0, ref_ovf(r.kind, r.ctrl[12], a, b)});
      end
      if ($urandom_range(0, 4) == 0) begin
        irq = $urandom_range(0, 1); exc = !irq || ($urandom_range(0, 1) == 1); #1;
        chk("trap_ctrl", 32'(obs_ctrl & M_OVR), 32'(pk(0,3,1,0,0,0,0,0,0,0,2,6'b0) & M_OVR));
      end
    end
    irq = 1'b0; exc = 1'b0;

    // RAM: directed write/read
    ram_write(32'h10, 32'hDEAD_BEEF);
    mem_rd = 1'b1; mem_addr = 32'h10; #1;
    chk("ram_rd_0x10", mem_rdata, 32'hDEAD_BEEF);
    mem_rd = 1'b0; #1;
    chk("ram_rd_off", mem_rdata, 32'h0);

    // Simultaneous read/write of the same word returns pre-edge data
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 32'h10; mem_wdata = 32'h1234_5678; #1;
    chk("rw_old_data", mem_rdata, 32'hDEAD_BEEF);
    clock_edge();
    mem_wr = 1'b0; ram_m[4] = 32'h1234_5678; #1;
    chk("rw_new_data", mem_rdata, 32'h1234_5678);

    // Random RAM traffic
    for (int n = 0; n < 120; n++) begin
      addr = {($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00, 20'h0, 8'($urandom), 2'($urandom)};
      data = $urandom;
      mem_rd = $urandom_range(0, 1);
      mem_addr = addr; #1;
      chk("ram_rd_pre", mem_rdata, mem_rd ? ram_m[addr[9:2]] : 32'h0);
      if ($urandom_range(0, 1) == 1) ram_write(addr, data);
      else clock_edge();
      mem_rd = 1'b1; #1;
      chk("ram_rd_post", mem_rdata, ram_m[addr[9:2]]);
    end

    // Reset mid-run: immediate clear, writes blocked while low
    ram_write(32'h10, 32'hCAFE_F00D);
    #2 reset = 1'b0;
    for (int i = 0; i < 256; i++) ram_m[i] = 32'h0;
    mem_rd = 1'b1; mem_addr = 32'h10; #1;
    chk("midreset_0x10", mem_rdata, 32'h0);
    ram_write(32'h20, 32'h5555_AAAA);
    #2 reset = 1'b1;
    mem_addr = 32'h20; #1;
    chk("write_in_reset", mem_rdata, 32'h0);
    ram_write(32'h20, 32'h0BAD_F00D);
    chk("write_after_reset", mem_rdata, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
